// File: rtl/move_checker_pkg.sv
// rtl/move_checker_pkg.sv - shared constants, FSM encoding and mask helper for move_checker
// Purpose: element count, default timing constants, FSM state encoding and
//          the num_play -> active-element mask helper.
// Ports:   none (package).
package move_checker_pkg;

    localparam int NUM_ELEM        = 13;
    localparam int TICK_DIV_DEF    = 50000;
    localparam int DEB_SAMPLES_DEF = 4;
    localparam int TIMEOUT_CYC_DEF = 100_000_000;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_RESULT  = 2'd3;

    // Bits below num_play are active. A count above NUM_ELEM leaves every
    // bit set, which gives the required clamp to NUM_ELEM for free.
    function automatic logic [NUM_ELEM-1:0] play_mask(input logic [3:0] num_play);
        logic [NUM_ELEM-1:0] m;
        for (int i = 0; i < NUM_ELEM; i++) begin
            m[i] = (i < int'(num_play));
        end
        return m;
    endfunction

endpackage

// File: rtl/move_checker_if.sv
// rtl/move_checker_if.sv - request/result and player-input bundle for move_checker
// Purpose: groups the start/move request, raw player inputs and result outputs.
// Ports:   master = game-control side (drives start, move, num_play, player_in)
//          slave  = move_checker (drives busy, done, pass, fail_wrong,
//                   fail_timeout, accepted)
interface move_checker_if;
    import move_checker_pkg::*;

    logic                start;
    logic [NUM_ELEM-1:0] move;
    logic [3:0]          num_play;
    logic [NUM_ELEM-1:0] player_in;
    logic                busy;
    logic                done;
    logic                pass;
    logic                fail_wrong;
    logic                fail_timeout;
    logic [NUM_ELEM-1:0] accepted;

    modport master (
        output start, move, num_play, player_in,
        input  busy, done, pass, fail_wrong, fail_timeout, accepted
    );

    modport slave (
        input  start, move, num_play, player_in,
        output busy, done, pass, fail_wrong, fail_timeout, accepted
    );

endinterface

// File: rtl/move_checker_input_debounce.sv
// rtl/move_checker_input_debounce.sv - 2-FF synchronizer plus tick-sampled debouncer for one input
// Purpose: synchronizes one raw input and changes the debounced level only
//          after DEB_SAMPLES consecutive tick samples disagree with it.
// Ports:   clk, rst_n (async active-low), tick_i (sample strobe), raw_i (async input),
//          level_o (debounced level), rise_o (one-cycle pulse, level went 0->1)
module input_debounce
    import move_checker_pkg::*;
#(
    parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic [2:0] cnt_q, cnt_d;

    // cnt_q counts prior consecutive disagreeing samples; the sample that
    // brings the run to DEB_SAMPLES flips the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (tick_i) begin
            if (sync2_q != level_q) begin
                if (cnt_q == 3'(DEB_SAMPLES - 1)) begin
                    level_d = sync2_q;
                    cnt_d   = 3'd0;
                    rise_d  = sync2_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else begin
                cnt_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/move_checker.sv
// rtl/move_checker.sv - checks debounced player presses against a target move mask
// Purpose: latches a target mask on start, waits for all inputs released,
//          then collects presses and reports pass / wrong input / timeout.
// Ports:   clk, rst_n (async active-low),
//          bus (slave): start, move, num_play, player_in in;
//                       busy, done, pass, fail_wrong, fail_timeout, accepted out
module move_checker
    import move_checker_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int DEB_SAMPLES = DEB_SAMPLES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    move_checker_if.slave bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                tick;
    logic [NUM_ELEM-1:0] level, rise;

    logic [1:0]          state_q, state_d;
    logic [NUM_ELEM-1:0] target_q, target_d;
    logic [NUM_ELEM-1:0] acc_q, acc_d;
    logic                pass_q, pass_d;
    logic                fw_q, fw_d;
    logic                ft_q, ft_d;
    logic [CW-1:0]       to_cnt_q, to_cnt_d;

    logic                wrong;
    logic [NUM_ELEM-1:0] acc_new;

    // One free-running tick shared by every debouncer.
    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    for (genvar g = 0; g < NUM_ELEM; g++) begin : g_deb
        input_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_i  (tick),
            .raw_i   (bus.player_in[g]),
            .level_o (level[g]),
            .rise_o  (rise[g])
        );
    end

    assign wrong   = |(rise & ~target_q);
    assign acc_new = acc_q | (rise & target_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        acc_d    = acc_q;
        pass_d   = pass_q;
        fw_d     = fw_q;
        ft_d     = ft_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_ARM;
                    target_d = bus.move & play_mask(bus.num_play);
                    acc_d    = '0;
                    pass_d   = 1'b0;
                    fw_d     = 1'b0;
                    ft_d     = 1'b0;
                    to_cnt_d = '0;
                end
            end
            ST_ARM: begin
                to_cnt_d = to_cnt_q + CW'(1);
                // A press still held over from the previous move must be
                // released before anything is collected.
                if (level == '0) begin
                    state_d = (target_q == '0) ? ST_RESULT : ST_COLLECT;
                end else if (to_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    ft_d    = 1'b1;
                    state_d = ST_RESULT;
                end
            end
            ST_COLLECT: begin
                to_cnt_d = to_cnt_q + CW'(1);
                if (wrong) begin
                    fw_d    = 1'b1;
                    state_d = ST_RESULT;
                end else begin
                    acc_d = acc_new;
                    if (acc_new == target_q) begin
                        pass_d  = 1'b1;
                        state_d = ST_RESULT;
                    end else if (to_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        ft_d    = 1'b1;
                        state_d = ST_RESULT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            target_q   <= '0;
            acc_q      <= '0;
            pass_q     <= 1'b0;
            fw_q       <= 1'b0;
            ft_q       <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            target_q   <= target_d;
            acc_q      <= acc_d;
            pass_q     <= pass_d;
            fw_q       <= fw_d;
            ft_q       <= ft_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_RESULT);
    assign bus.pass         = pass_q;
    assign bus.fail_wrong   = fw_q;
    assign bus.fail_timeout = ft_q;
    assign bus.accepted     = acc_q;

endmodule

// File: tb/tb_move_checker.sv
// tb/tb_move_checker.sv - directed table-driven testbench for move_checker
module tb_move_checker;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   done_cnt;

    move_checker_if mc_if();

    move_checker #(
        .TICK_DIV    (2),
        .DEB_SAMPLES (2),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mc_if.done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [12:0] mv;
        logic [3:0]  np;
        logic [12:0] press;
        logic        ep;
        logic        ew;
        logic        et;
        logic [12:0] eacc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start a move and drive player_in: p0 while k<t_rel, p1 for t_press<=k<t_end.
    task automatic run_move(input logic [12:0] mv, input logic [3:0] np,
                            input logic [12:0] p0, input logic [12:0] p1,
                            input int t_rel, input int t_press, input int t_end,
                            output int done_k);
        int  k;
        bit  seen;
        @(negedge clk);
        mc_if.move     = mv;
        mc_if.num_play = np;
        mc_if.start    = 1'b1;
        @(negedge clk);
        mc_if.start = 1'b0;
        chk("busy_after_start", 32'(mc_if.busy), 32'd1);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            @(negedge clk);
            k++;
            if (mc_if.done) seen = 1'b1;
            else mc_if.player_in = (k < t_rel) ? p0 :
                                   (k >= t_press && k < t_end) ? p1 : 13'h0;
        end
        done_k = k;
        chk("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("done_one_cycle_busy_low", {30'd0, mc_if.done, mc_if.busy}, 32'd0);
    endtask

    initial begin
        int  dk;
        bit  seen;
        total           = 0;
        bad             = 0;
        done_cnt        = 0;
        rst_n           = 1'b0;
        mc_if.start     = 1'b0;
        mc_if.move      = '0;
        mc_if.num_play  = '0;
        mc_if.player_in = '0;

        //          mv       np     press    ep ew et eacc
        vecs[0] = '{13'h004, 4'd8,  13'h004, 1, 0, 0, 13'h004};
        vecs[1] = '{13'h003, 4'd8,  13'h020, 0, 1, 0, 13'h000};
        vecs[2] = '{13'h1003,4'd4,  13'h003, 1, 0, 0, 13'h003};
        vecs[3] = '{13'h009, 4'd8,  13'h009, 1, 0, 0, 13'h009};
        vecs[4] = '{13'h001, 4'd8,  13'h009, 0, 1, 0, 13'h000};
        vecs[5] = '{13'h1fff,4'd15, 13'h1fff,1, 0, 0, 13'h1fff};
        vecs[6] = '{13'h1000,4'd12, 13'h000, 0, 0, 0, 13'h000};
        vecs[7] = '{13'h002, 4'd8,  13'h000, 0, 0, 1, 13'h000};
        vecs[8] = '{13'h003, 4'd8,  13'h001, 0, 0, 1, 13'h001};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {mc_if.busy, mc_if.done, mc_if.pass, mc_if.fail_wrong,
                              mc_if.fail_timeout, mc_if.accepted}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", {31'd0, mc_if.busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_move(vecs[i].mv, vecs[i].np, 13'h0, vecs[i].press, 0, 3, 15, dk);
            chk($sformatf("v%0d_pass", i), 32'(mc_if.pass), 32'(vecs[i].ep));
            chk($sformatf("v%0d_fail_wrong", i), 32'(mc_if.fail_wrong), 32'(vecs[i].ew));
            chk($sformatf("v%0d_fail_timeout", i), 32'(mc_if.fail_timeout), 32'(vecs[i].et));
            chk($sformatf("v%0d_accepted", i), 32'(mc_if.accepted), 32'(vecs[i].eacc));
            if (vecs[i].et) chk($sformatf("v%0d_timeout_cycle", i), 32'(dk >= 195 && dk <= 205), 32'd1);
            mc_if.player_in = '0;
            repeat (15) @(negedge clk);
        end

        // Multi-target with a target bounce and a non-target glitch.
        @(negedge clk);
        mc_if.move = 13'h091; mc_if.num_play = 4'd8; mc_if.start = 1'b1;
        @(negedge clk);
        mc_if.start = 1'b0;
        dk = done_cnt;
        repeat (3) @(negedge clk);
        mc_if.player_in = 13'h001; repeat (10) @(negedge clk);
        mc_if.player_in = 13'h000; repeat (10) @(negedge clk);
        chk("multi_acc1", 32'(mc_if.accepted), 32'h001);
        mc_if.player_in = 13'h001; @(negedge clk);
        mc_if.player_in = 13'h000; repeat (3) @(negedge clk);
        mc_if.player_in = 13'h008; @(negedge clk);
        mc_if.player_in = 13'h000; repeat (10) @(negedge clk);
        chk("multi_glitch_acc", 32'(mc_if.accepted), 32'h001);
        chk("multi_glitch_no_done", 32'(done_cnt - dk), 32'd0);
        mc_if.player_in = 13'h010; repeat (10) @(negedge clk);
        mc_if.player_in = 13'h000; repeat (10) @(negedge clk);
        chk("multi_acc2", 32'(mc_if.accepted), 32'h011);
        chk("multi_no_early_done", 32'(done_cnt - dk), 32'd0);
        mc_if.player_in = 13'h080;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (mc_if.done) seen = 1'b1;
        end
        chk("multi_done_seen", 32'(seen), 32'd1);
        chk("multi_result", {mc_if.pass, mc_if.fail_wrong, mc_if.fail_timeout, mc_if.accepted},
            {16'd0, 3'b100, 13'h091});
        mc_if.player_in = '0;
        repeat (15) @(negedge clk);

        // ARM gating: a held input blocks collection until released.
        mc_if.player_in = 13'h001;
        repeat (20) @(negedge clk);
        run_move(13'h001, 4'd8, 13'h001, 13'h000, 400, 400, 400, dk);
        chk("arm_hold_timeout", {mc_if.pass, mc_if.fail_wrong, mc_if.fail_timeout}, 32'b001);
        chk("arm_hold_cycle", 32'(dk >= 195 && dk <= 205), 32'd1);
        run_move(13'h001, 4'd8, 13'h001, 13'h001, 30, 45, 60, dk);
        chk("arm_release_pass", {mc_if.pass, mc_if.fail_wrong, mc_if.fail_timeout}, 32'b100);
        chk("arm_release_late", 32'(dk >= 45), 32'd1);
        mc_if.player_in = '0;
        repeat (15) @(negedge clk);

        // Second start while busy must not replace the target.
        @(negedge clk);
        mc_if.move = 13'h001; mc_if.num_play = 4'd8; mc_if.start = 1'b1;
        @(negedge clk);
        mc_if.start = 1'b0;
        repeat (3) @(negedge clk);
        mc_if.move = 13'h002; mc_if.start = 1'b1;
        @(negedge clk);
        mc_if.start = 1'b0;
        mc_if.player_in = 13'h001;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (mc_if.done) seen = 1'b1;
        end
        chk("busy_start_done", 32'(seen), 32'd1);
        chk("busy_start_ignored", {mc_if.pass, mc_if.fail_wrong, mc_if.accepted},
            {17'd0, 2'b10, 13'h001});
        mc_if.player_in = '0;
        repeat (15) @(negedge clk);

        // Reset mid-COLLECT aborts without a done pulse.
        @(negedge clk);
        mc_if.move = 13'h003; mc_if.num_play = 4'd8; mc_if.start = 1'b1;
        @(negedge clk);
        mc_if.start = 1'b0;
        repeat (3) @(negedge clk);
        mc_if.player_in = 13'h001; repeat (10) @(negedge clk);
        mc_if.player_in = 13'h000; repeat (10) @(negedge clk);
        chk("pre_reset_acc", 32'(mc_if.accepted), 32'h001);
        dk = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {mc_if.busy, mc_if.done, mc_if.pass, mc_if.fail_wrong,
                                    mc_if.fail_timeout, mc_if.accepted}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("reset_no_done", 32'(done_cnt - dk), 32'd0);
        chk("reset_stays_idle", {31'd0, mc_if.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
